// File: rtl/serial_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and
// the fixed 8N1 frame constants.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when
// empty are ignored, and storage is not reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/serial_tx.sv
// Buffered 8N1 UART transmitter: characters queue in a FIFO and are
// shifted out LSB first on a registered, idle-high line.
module serial_tx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_ch_valid,
    input  logic [7:0] i_ch,
    output logic       o_ch_ready,
    output logic       o_txd,
    output logic       o_busy,
    output logic       o_ovf
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_dout;
    logic             push;
    logic             pop;

    tx_state_t        state, state_next;
    logic [BAUD_W-1:0] baud_cnt, baud_next;
    logic [2:0]       bit_cnt, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             baud_end;
    logic             txd_next;

    assign o_ch_ready = !fifo_full;
    assign push       = i_ch_valid && o_ch_ready;
    assign o_busy     = (state != IDLE) || (fifo_count != '0);
    assign baud_end   = (baud_cnt == BAUD_LAST);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (i_ch),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_dout;
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_cnt == BIT_LAST) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Line value is taken from the next state so o_txd lines up with state
        case (state_next)
            START:   txd_next = START_BIT;
            DATA:    txd_next = shift_next[0];
            default: txd_next = STOP_BIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            o_txd    <= STOP_BIT;
            o_ovf    <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            o_txd    <= txd_next;
            if (i_ch_valid && !o_ch_ready) o_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        shift_reg <= shift_next;
    end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: a frame-timing model predicts pops and
// flags, and an independent line monitor decodes and checks each frame.
module tb_serial_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic       clock;
    logic       reset;
    logic       i_ch_valid;
    logic [7:0] i_ch;
    logic       o_ch_ready;
    logic       o_txd;
    logic       o_busy;
    logic       o_ovf;

    serial_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .i_ch_valid (i_ch_valid),
        .i_ch       (i_ch),
        .o_ch_ready (o_ch_ready),
        .o_txd      (o_txd),
        .o_busy     (o_busy),
        .o_ovf      (o_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   cyc = 0;
    logic rst_q = 1'b1;
    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    typedef struct {
        logic [7:0] ch;
        int         start;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mq[$];
    bit         have_pop = 1'b0;
    int         last_pop = 0;
    bit         m_ovf = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         target;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rnd8();
        return 8'($urandom_range(255, 0));
    endfunction

    // One clock cycle: check outputs against the model, then drive inputs
    task automatic step(input bit v, input logic [7:0] ch, input bit r);
        int   t;
        bit   idle;
        bit   acc;
        exp_t e;
        @(negedge clock);
        t = cyc;
        if (t > 0) begin
            check("ready", int'(o_ch_ready), int'(mq.size() < DEPTH));
            check("busy", int'(o_busy),
                  int'(mq.size() != 0 || (have_pop && t <= last_pop + FRAME)));
            check("ovf", int'(o_ovf), int'(m_ovf));
        end
        reset      = r;
        i_ch_valid = v;
        i_ch       = ch;
        if (r) begin
            mq.delete();
            have_pop = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            idle = !have_pop || (t > last_pop + FRAME);
            acc  = v && (mq.size() < DEPTH);
            if (v && !acc) m_ovf = 1'b1;
            if (idle && mq.size() > 0) begin
                e.ch    = mq.pop_front();
                e.start = t + 1;
                sb.push_back(e);
                have_pop = 1'b1;
                last_pop = t;
            end
            if (acc) mq.push_back(ch);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (mq.size() == 0 && (!have_pop || cyc > last_pop + FRAME + 2)) break;
            step(1'b0, 8'h00, 1'b0);
        end
        check("drained_frames_left", sb.size(), 0);
    endtask

    // Line monitor: decodes frames from o_txd alone
    initial begin
        bit         in_frame;
        int         start;
        logic       smp [FRAME];
        logic [7:0] data;
        bit         ok;
        int         b;
        logic       want;
        exp_t       e;
        in_frame = 1'b0;
        start    = 0;
        forever begin
            @(negedge clock);
            if (rst_q) begin
                if (cyc > 0) check("txd_high_in_reset", int'(o_txd), 1);
                in_frame = 1'b0;
                sb.delete();
            end else if (!in_frame) begin
                if (o_txd == 1'b0) begin
                    in_frame = 1'b1;
                    start    = cyc;
                    smp[0]   = o_txd;
                end
            end else begin
                smp[cyc - start] = o_txd;
                if (cyc - start == FRAME - 1) begin
                    in_frame = 1'b0;
                    ok = 1'b1;
                    for (int k = 0; k < FRAME; k++) begin
                        b = k / CPB;
                        if (b == 0) want = 1'b0;
                        else if (b == 9) want = 1'b1;
                        else want = smp[b * CPB];
                        if (smp[k] !== want) ok = 1'b0;
                    end
                    for (int i = 0; i < 8; i++) data[i] = smp[(i + 1) * CPB + CPB / 2];
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("frame_start", start, e.start);
                        check("frame_char", int'(data), int'(e.ch));
                        check("frame_shape", int'(ok), 1);
                    end
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        i_ch_valid = 1'b0;
        i_ch       = 8'h00;
        repeat (3) step(1'b0, 8'h00, 1'b1);

        step(1'b1, 8'h41, 1'b0);
        drain();

        for (int i = 0; i < 10; i++) step(1'b1, rnd8(), 1'b0);
        target = last_pop + FRAME + 1;
        while (cyc + 1 < target) step(1'b0, 8'h00, 1'b0);
        step(1'b1, rnd8(), 1'b0);
        drain();

        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        drain();

        step(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, rnd8(), 1'b0);
        target = last_pop + 1 + 4 * CPB + 1;
        while (cyc + 1 < target) step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        repeat (150) step(1'b0, 8'h00, 1'b0);

        for (int blk = 0; blk < 10; blk++) begin
            int dens;
            dens = (blk % 3 == 0) ? 90 : ((blk % 3 == 1) ? 30 : 5);
            for (int i = 0; i < 250; i++)
                step($urandom_range(99, 0) < dens, rnd8(), 1'b0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter CLKS_PER_BIT, default 16, SHALL set the clock cycles per UART bit; legal range is 2..65535.
REQ-003 Parameter FIFO_DEPTH, default 8, SHALL set the number of character buffer entries; it is a power of two, minimum 2.
REQ-004 Port clock, input, 1 bit, SHALL be the core clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-006 Port i_ch_valid, input, 1 bit, SHALL be the character strobe from the writeback stage (putch), one character per high cycle.
REQ-007 Port i_ch, input, 8 bits, SHALL carry the character, sampled when i_ch_valid is high.
REQ-008 Port o_ch_ready, output, 1 bit, SHALL be high when count < FIFO_DEPTH (combinational from count).
REQ-009 Port o_txd, output, 1 bit, SHALL be the registered UART line, idle high.
REQ-010 Port o_busy, output, 1 bit, SHALL be high when state != IDLE or count != 0.
REQ-011 Port o_ovf, output, 1 bit, SHALL be a sticky flag that sets when a character is dropped.

Function
REQ-012 A push SHALL occur when i_ch_valid && o_ch_ready; the character is written at the write pointer and count increments.
REQ-013 When i_ch_valid is high and the FIFO is full, the character SHALL be dropped, o_ovf SHALL set the next cycle, and FIFO contents SHALL be unchanged.
REQ-014 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-015 A push and a pop in the same cycle SHALL leave count unchanged; a full FIFO SHALL reject the push even if a pop occurs that cycle.
REQ-016 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-017 In IDLE with count > 0, the block SHALL pop the head into an 8-bit shift register, clear the bit counter and the baud counter, and enter START.
REQ-018 START SHALL drive o_txd = 0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-019 DATA SHALL drive the 8 bits LSB first, each for CLKS_PER_BIT cycles; after bit 7 it SHALL enter STOP.
REQ-020 STOP SHALL drive o_txd = 1 for CLKS_PER_BIT cycles, then enter IDLE.
REQ-021 IDLE SHALL last at least one cycle, so back-to-back frames are 10*CLKS_PER_BIT + 1 cycles apart.
REQ-022 A push at cycle t into an empty FIFO with the FSM in IDLE SHALL pop at t+1, and o_txd SHALL first read 0 in cycle t+2.
REQ-023 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap, with width clog2(CLKS_PER_BIT); the bit counter SHALL be 3 bits.
REQ-024 A push arriving during a frame SHALL NOT disturb the frame in progress.

Reset
REQ-025 On reset: state = IDLE, o_txd = 1, count = 0, pointers = 0, o_ovf = 0, counters = 0; o_ch_ready = 1 and o_busy = 0 from the first post-reset cycle.
REQ-026 Reset mid-frame SHALL abort the frame: o_txd returns to 1 in the cycle after reset is sampled, and buffered characters are discarded.
REQ-027 o_ovf SHALL clear only on reset.

Structure
REQ-028 The FSM state enum and the UART frame constants (START_BIT = 0, STOP_BIT = 1, DATA_BITS = 8) SHALL live in the shared package serial_pkg.
REQ-029 The FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count); the FSM and shifter SHALL stay in serial_tx.

Verification
REQ-030 With CLKS_PER_BIT=4, push 0x41 at cycle 0 -> o_txd = 0 from cycle 2 for 4 cycles; then bits 1,0,0,0,0,0,1,0 at 4 cycles each; then 1 for 4 cycles; o_busy falls at cycle 42.
REQ-031 Push 10 characters on consecutive cycles 0..9 -> characters 0..8 accepted; o_ch_ready low at cycle 9; character 9 dropped; o_ovf = 1 from cycle 10; 9 frames emitted in order.
REQ-032 Push 0x55 and 0xAA back-to-back -> second START begins exactly 10*CLKS_PER_BIT + 1 cycles after the first START.
REQ-033 Assert reset during DATA bit 3 of 0xFF with 3 characters queued -> o_txd = 1 the next cycle; count = 0; o_busy = 0; no further frames.
REQ-034 With the FIFO full, assert i_ch_valid in the same cycle the FSM pops -> push rejected, o_ovf set, count = FIFO_DEPTH-1 the next cycle.
